// File: rtl/hazard_unit.sv
// Hazard detection and forwarding controller for the 5-stage RISC-V pipeline.
// Tracks E/M/W register addresses, memory-wait stalls and hazard counters.
module hazard_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdD,
    input  logic             reg_writeM,
    input  logic             reg_writeW,
    input  logic             result_srcE0,
    input  logic             PC_srcE,
    input  logic             mem_reqM,
    input  logic             mem_ready,
    output logic [4:0]       rs1E,
    output logic [4:0]       rs2E,
    output logic [4:0]       rdE,
    output logic [4:0]       rdM,
    output logic [4:0]       rdW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int               WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic              mem_wait;
    logic              lw_stall;
    logic [WAIT_W-1:0] wait_cnt;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic we_m, input logic [4:0] rd_w,
                                           input logic we_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && rs == rd_m && we_m)
            sel = 2'b10;
        else if (rs != 5'd0 && rs == rd_w && we_w)
            sel = 2'b01;
        return sel;
    endfunction

    // A pending memory access overrides everything; a taken branch cancels a load-use stall.
    always_comb begin
        mem_wait  = mem_reqM & ~mem_ready;
        lw_stall  = result_srcE0 & (rdE != 5'd0) & ((rs1D == rdE) | (rs2D == rdE)) & ~PC_srcE;
        stallF    = mem_wait | lw_stall;
        stallD    = mem_wait | lw_stall;
        stallE    = mem_wait;
        stallM    = mem_wait;
        flushW    = mem_wait;
        flushD    = PC_srcE & ~mem_wait;
        flushE    = (PC_srcE | lw_stall) & ~mem_wait;
        forwardAE = fwd_sel(rs1E, rdM, reg_writeM, rdW, reg_writeW);
        forwardBE = fwd_sel(rs2E, rdM, reg_writeM, rdW, reg_writeW);
    end

    // During a memory wait E and M hold while W receives a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs1E <= 5'd0;
            rs2E <= 5'd0;
            rdE  <= 5'd0;
            rdM  <= 5'd0;
            rdW  <= 5'd0;
        end else if (mem_wait) begin
            rdW <= 5'd0;
        end else begin
            if (flushE) begin
                rs1E <= 5'd0;
                rs2E <= 5'd0;
                rdE  <= 5'd0;
            end else begin
                rs1E <= rs1D;
                rs2E <= rs2D;
                rdE  <= rdD;
            end
            rdM <= rdE;
            rdW <= rdM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallF && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flushD && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // The flag rises on the edge that brings the wait count up to TIMEOUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_wait) begin
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt >= WAIT_MAX - WAIT_W'(1))
                mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule
